// File: rtl/param_tx.sv
// rtl/param_tx.sv - MBINIT.PARAM initiator: sends configuration_req, awaits configuration_resp, drives checker
module param_tx #(
    parameter int SB_MSG_Width   = 4,
    parameter int TIMEOUT_CYCLES = 8000000
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_MBINIT_en,
    input  logic                    i_sb_busy,
    input  logic                    i_falling_edge_busy,
    input  logic                    i_sb_valid,
    input  logic [SB_MSG_Width-1:0] i_decoded_sb_msg,
    input  logic                    i_finish,
    input  logic                    i_param_ok,
    output logic [SB_MSG_Width-1:0] o_encoded_SB_msg,
    output logic                    o_msg_valid,
    output logic                    o_check_en,
    output logic                    o_PARAM_UP_end,
    output logic                    o_param_err,
    output logic                    o_timeout_err
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0] T_MAX  = TW'(TIMEOUT_CYCLES);
    localparam logic [SB_MSG_Width-1:0] MSG_REQ  = SB_MSG_Width'(1);
    localparam logic [SB_MSG_Width-1:0] MSG_RESP = SB_MSG_Width'(2);

    typedef enum logic [2:0] {
        IDLE,
        CHECK_SB,
        SEND_REQ,
        WAIT_RESP,
        CHECK_RESP,
        PARAM_END,
        ERROR
    } state_t;

    state_t                  state, ns;
    logic [TW-1:0]           timer, timer_n;
    logic                    early_resp, early_resp_n;
    logic                    counting, resp_seen, param_fail, tmo_hit;
    logic [SB_MSG_Width-1:0] msg_n;
    logic                    msg_valid_n, check_en_n, end_n, param_err_n, timeout_err_n;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state            <= IDLE;
            timer            <= '0;
            early_resp       <= 1'b0;
            o_encoded_SB_msg <= '0;
            o_msg_valid      <= 1'b0;
            o_check_en       <= 1'b0;
            o_PARAM_UP_end   <= 1'b0;
            o_param_err      <= 1'b0;
            o_timeout_err    <= 1'b0;
        end else begin
            state            <= ns;
            timer            <= timer_n;
            early_resp       <= early_resp_n;
            o_encoded_SB_msg <= msg_n;
            o_msg_valid      <= msg_valid_n;
            o_check_en       <= check_en_n;
            o_PARAM_UP_end   <= end_n;
            o_param_err      <= param_err_n;
            o_timeout_err    <= timeout_err_n;
        end
    end

    always_comb begin
        ns            = state;
        param_fail    = 1'b0;
        tmo_hit       = 1'b0;
        counting      = (state == CHECK_SB) || (state == SEND_REQ) ||
                        (state == WAIT_RESP) || (state == CHECK_RESP);
        resp_seen     = i_sb_valid && (i_decoded_sb_msg == MSG_RESP);

        case (state)
            IDLE:       if (i_MBINIT_en) ns = CHECK_SB;
            CHECK_SB:   if (!i_sb_busy) ns = SEND_REQ;
            SEND_REQ:   if (i_falling_edge_busy) ns = WAIT_RESP;
            WAIT_RESP:  if (resp_seen || early_resp) ns = CHECK_RESP;
            CHECK_RESP: begin
                if (i_finish) begin
                    if (i_param_ok) begin
                        ns = PARAM_END;
                    end else begin
                        ns         = ERROR;
                        param_fail = 1'b1;
                    end
                end
            end
            PARAM_END:  ns = PARAM_END;
            ERROR:      ns = ERROR;
            default:    ns = IDLE;
        endcase

        // Any forward move in the cycle the budget runs out takes priority over the timeout.
        if (counting && (ns == state) && (timer >= T_LAST)) begin
            ns      = ERROR;
            tmo_hit = 1'b1;
        end

        if (!i_MBINIT_en) ns = IDLE;

        timer_n = timer;
        if (!i_MBINIT_en || state == IDLE) begin
            timer_n = '0;
        end else if (counting && timer != T_MAX) begin
            timer_n = timer + 1'b1;
        end

        early_resp_n = early_resp;
        if (!i_MBINIT_en || state == IDLE || state == WAIT_RESP) begin
            early_resp_n = 1'b0;
        end else if (state == SEND_REQ && resp_seen) begin
            early_resp_n = 1'b1;
        end

        msg_valid_n   = (ns == SEND_REQ);
        msg_n         = (ns == SEND_REQ) ? MSG_REQ : '0;
        check_en_n    = (ns == CHECK_RESP);
        end_n         = (ns == PARAM_END);
        param_err_n   = (ns == ERROR) && ((state == ERROR) ? o_param_err   : param_fail);
        timeout_err_n = (ns == ERROR) && ((state == ERROR) ? o_timeout_err : tmo_hit);
    end

endmodule
